// File: rtl/mux_1_2_hls_dbg_pkg.sv
// Shared debug-logic package for the mux_1_2 HLS instance.
// Contents:
//   stall_state_t            per-channel stall FSM state encoding
//   DEFAULT_STALL_THRESHOLD  default consecutive-stall cycle count before a port is flagged
//   clog2_min1               index-width helper that never returns 0
package mux_1_2_hls_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    BLOCKED = 2'd2
  } stall_state_t;

  localparam int DEFAULT_STALL_THRESHOLD = 16;

  // A single-port vector still needs a 1-bit index, so clamp to 1.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_1_2_hls_axis_stall_chan.sv
// One AXI-Stream port's stall detector: stall decode, stall FSM and run counter.
// Ports:
//   clock, reset   clock and synchronous active-high reset
//   inst_idle      instance idle; masks the stall condition
//   tvalid,tready  handshake of the monitored port
//   blocked        registered flag, high while the FSM sits in BLOCKED
//   blocked_next   value blocked takes at the next edge (for edge detection upstream)
module mux_1_2_hls_axis_stall_chan
  import mux_1_2_hls_dbg_pkg::*;
#(
  parameter int STALL_THRESHOLD = DEFAULT_STALL_THRESHOLD,
  parameter bit IS_OUTPUT       = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic inst_idle,
  input  logic tvalid,
  input  logic tready,
  output logic blocked,
  output logic blocked_next
);

  localparam int CNT_W = $clog2(STALL_THRESHOLD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_THRESHOLD - 1);

  stall_state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic stall;

  // A master stalls on back-pressure, a slave stalls when starved; a handshake never stalls.
  always_comb begin
    if (inst_idle) begin
      stall = 1'b0;
    end else if (IS_OUTPUT) begin
      stall = tvalid & ~tready;
    end else begin
      stall = tready & ~tvalid;
    end
  end

  // State, counter and flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      blocked <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      blocked <= blocked_next;
    end
  end

  // Next-state and counter logic. cnt holds the number of stalled cycles seen so far.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (stall) begin
          state_next = WAIT;
          cnt_next   = CNT_W'(1);
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (!stall) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = BLOCKED;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      BLOCKED: begin
        if (!stall) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          state_next = BLOCKED;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    blocked_next = (state_next == BLOCKED);
  end

endmodule

// File: rtl/mux_1_2_hls_axis_stall_detector.sv
// Per-port AXI-Stream stall detector for the mux_1_2 instance (1 input, 2 output streams).
// Drives the deadlock monitor's axis_block_sigs and keeps debug capture state.
// Ports:
//   clock, reset     clock and synchronous active-high reset
//   inst_idle        instance ap_idle; forces every channel to IDLE
//   port_tvalid/port_tready  handshake of each monitored port
//   evt_clear        clears first_blk_* and evt_count (has priority over a same-cycle rise)
//   axis_block_sigs  registered per-port blocked flags
//   first_blk_valid  sticky: some port has been flagged since reset/clear
//   first_blk_id     index of the first flagged port (lowest index on ties)
//   evt_count        saturating count of cycles in which any flag rises
module mux_1_2_hls_axis_stall_detector
  import mux_1_2_hls_dbg_pkg::*;
#(
  parameter int                   NUM_PORTS       = 3,
  parameter logic [NUM_PORTS-1:0] PORT_IS_OUTPUT  = 3'b110,
  parameter int                   STALL_THRESHOLD = DEFAULT_STALL_THRESHOLD,
  parameter int                   EVT_CNT_W       = 16,
  localparam int                  ID_W            = clog2_min1(NUM_PORTS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inst_idle,
  input  logic [NUM_PORTS-1:0] port_tvalid,
  input  logic [NUM_PORTS-1:0] port_tready,
  input  logic                 evt_clear,
  output logic [NUM_PORTS-1:0] axis_block_sigs,
  output logic                 first_blk_valid,
  output logic [ID_W-1:0]      first_blk_id,
  output logic [EVT_CNT_W-1:0] evt_count
);

  logic [NUM_PORTS-1:0] blk_next;
  logic [NUM_PORTS-1:0] blk_rise;
  logic [ID_W-1:0]      rise_idx;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_chan
    mux_1_2_hls_axis_stall_chan #(
      .STALL_THRESHOLD (STALL_THRESHOLD),
      .IS_OUTPUT       (PORT_IS_OUTPUT[i])
    ) u_chan (
      .clock        (clock),
      .reset        (reset),
      .inst_idle    (inst_idle),
      .tvalid       (port_tvalid[i]),
      .tready       (port_tready[i]),
      .blocked      (axis_block_sigs[i]),
      .blocked_next (blk_next[i])
    );
  end

  assign blk_rise = blk_next & ~axis_block_sigs;

  // Lowest rising index: scan downward so the lowest set bit is assigned last.
  always_comb begin
    rise_idx = {ID_W{1'b0}};
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (blk_rise[i]) begin
        rise_idx = ID_W'(i);
      end else begin
        rise_idx = rise_idx;
      end
    end
  end

  // First-blocked capture and saturating event counter; clear beats a same-cycle rise.
  always_ff @(posedge clock) begin
    if (reset || evt_clear) begin
      first_blk_valid <= 1'b0;
      first_blk_id    <= {ID_W{1'b0}};
      evt_count       <= {EVT_CNT_W{1'b0}};
    end else if (|blk_rise) begin
      if (evt_count != {EVT_CNT_W{1'b1}}) begin
        evt_count <= evt_count + EVT_CNT_W'(1);
      end
      if (!first_blk_valid) begin
        first_blk_valid <= 1'b1;
        first_blk_id    <= rise_idx;
      end
    end
  end

endmodule

// File: tb/tb_mux_1_2_hls_axis_stall_detector.sv
module tb_mux_1_2_hls_axis_stall_detector;

  localparam int       NP   = 3;
  localparam int       T    = 4;
  localparam int       CW   = 8;
  localparam bit [2:0] POUT = 3'b110;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          inst_idle = 1'b0;
  logic [NP-1:0] port_tvalid = '0;
  logic [NP-1:0] port_tready = '0;
  logic          evt_clear = 1'b0;
  logic [NP-1:0] axis_block_sigs;
  logic          first_blk_valid;
  logic [1:0]    first_blk_id;
  logic [CW-1:0] evt_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]    blk;
    logic          fv;
    logic [1:0]    fid;
    logic [CW-1:0] cnt;
  } exp_t;
  exp_t sb_q[$];

  // reference model state
  int            m_run[NP];
  logic [2:0]    m_blk = '0;
  logic          m_fv  = 1'b0;
  logic [1:0]    m_fid = '0;
  logic [CW-1:0] m_cnt = '0;

  mux_1_2_hls_axis_stall_detector #(
    .NUM_PORTS       (NP),
    .PORT_IS_OUTPUT  (POUT),
    .STALL_THRESHOLD (T),
    .EVT_CNT_W       (CW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .inst_idle       (inst_idle),
    .port_tvalid     (port_tvalid),
    .port_tready     (port_tready),
    .evt_clear       (evt_clear),
    .axis_block_sigs (axis_block_sigs),
    .first_blk_valid (first_blk_valid),
    .first_blk_id    (first_blk_id),
    .evt_count       (evt_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, push the model's prediction, then compare after the edge.
  task automatic step(input logic rst, input logic idle, input logic [2:0] v,
                      input logic [2:0] r, input logic clr);
    logic [2:0] st, nf, rise;
    exp_t e, got;
    for (int i = 0; i < NP; i++)
      st[i] = !idle && (POUT[i] ? (v[i] && !r[i]) : (r[i] && !v[i]));
    if (rst) begin
      for (int i = 0; i < NP; i++) m_run[i] = 0;
      m_blk = '0; m_fv = 1'b0; m_fid = '0; m_cnt = '0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        m_run[i] = st[i] ? ((m_run[i] < T) ? m_run[i] + 1 : T) : 0;
        nf[i] = (m_run[i] >= T);
      end
      rise = nf & ~m_blk;
      if (clr) begin
        m_fv = 1'b0; m_fid = '0; m_cnt = '0;
      end else if (rise != 3'b000) begin
        if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        if (!m_fv) begin
          m_fv  = 1'b1;
          m_fid = rise[0] ? 2'd0 : (rise[1] ? 2'd1 : 2'd2);
        end
      end
      m_blk = nf;
    end
    e.blk = m_blk; e.fv = m_fv; e.fid = m_fid; e.cnt = m_cnt;
    sb_q.push_back(e);
    reset = rst; inst_idle = idle; port_tvalid = v; port_tready = r; evt_clear = clr;
    @(posedge clock);
    #1;
    got = sb_q.pop_front();
    check("sb_blk", {29'd0, axis_block_sigs}, {29'd0, got.blk});
    check("sb_fv",  {31'd0, first_blk_valid}, {31'd0, got.fv});
    check("sb_fid", {30'd0, first_blk_id},    {30'd0, got.fid});
    check("sb_cnt", {24'd0, evt_count},       {24'd0, got.cnt});
  endtask

  task automatic quiet(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NP; i++) m_run[i] = 0;
    // reset state
    step(1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
    step(1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
    check("rst_blk", axis_block_sigs, 3'b000);
    check("rst_cnt", evt_count, 8'd0);
    check("rst_fv",  first_blk_valid, 1'b0);
    quiet(2);

    // output port 1 back-pressured for T cycles
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 3'b010, 3'b000, 1'b0);
    check("p1_early", axis_block_sigs, 3'b000);
    step(1'b0, 1'b0, 3'b010, 3'b000, 1'b0);
    check("p1_blk", axis_block_sigs, 3'b010);
    check("p1_cnt", evt_count, 8'd1);
    check("p1_fid", first_blk_id, 2'd1);
    check("p1_fv",  first_blk_valid, 1'b1);
    step(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
    check("p1_drop", axis_block_sigs, 3'b000);

    // input port 0 starved 3, handshake, starved 3: never flagged
    step(1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 3'b000, 3'b001, 1'b0);
    step(1'b0, 1'b0, 3'b001, 3'b001, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 3'b000, 3'b001, 1'b0);
    quiet(1);
    check("gap_blk", axis_block_sigs, 3'b000);
    check("gap_cnt", evt_count, 8'd0);

    // ports 1 and 2 together, then inst_idle on blocked port 2
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 3'b110, 3'b000, 1'b0);
    check("pair_blk", axis_block_sigs, 3'b110);
    check("pair_cnt", evt_count, 8'd1);
    check("pair_fid", first_blk_id, 2'd1);
    step(1'b0, 1'b0, 3'b100, 3'b000, 1'b0);
    check("p2_only", axis_block_sigs, 3'b100);
    step(1'b0, 1'b1, 3'b100, 3'b000, 1'b0);
    check("idle_drop", axis_block_sigs, 3'b000);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 3'b100, 3'b000, 1'b0);
    check("restall_early", axis_block_sigs, 3'b000);
    step(1'b0, 1'b0, 3'b100, 3'b000, 1'b0);
    check("restall_blk", axis_block_sigs, 3'b100);
    check("restall_cnt", evt_count, 8'd2);
    check("restall_fid", first_blk_id, 2'd1);
    quiet(1);

    // saturation: more rises than the counter can hold
    step(1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
    for (int n = 0; n < (1 << CW) + 2; n++) begin
      for (int k = 0; k < T; k++) step(1'b0, 1'b0, 3'b000, 3'b001, 1'b0);
      step(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
    end
    check("sat_cnt", evt_count, 8'hFF);
    check("sat_fid", first_blk_id, 2'd0);

    // reset in the middle of a stall
    for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 3'b010, 3'b000, 1'b0);
    step(1'b1, 1'b0, 3'b010, 3'b000, 1'b0);
    check("mid_rst_blk", axis_block_sigs, 3'b000);
    check("mid_rst_cnt", evt_count, 8'd0);
    check("mid_rst_fv",  first_blk_valid, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 3'b010, 3'b000, 1'b0);
    check("post_rst_early", axis_block_sigs, 3'b000);
    step(1'b0, 1'b0, 3'b010, 3'b000, 1'b0);
    check("post_rst_blk", axis_block_sigs, 3'b010);
    check("post_rst_cnt", evt_count, 8'd1);
    quiet(1);

    // clear in the same cycle as a rise: the rise is lost
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 3'b100, 3'b000, 1'b0);
    step(1'b0, 1'b0, 3'b100, 3'b000, 1'b1);
    check("clr_rise_blk", axis_block_sigs, 3'b100);
    check("clr_rise_cnt", evt_count, 8'd0);
    check("clr_rise_fv",  first_blk_valid, 1'b0);
    quiet(1);

    // random traffic against the model
    for (int k = 0; k < 400; k++)
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
           3'($urandom_range(0, 7)) | ((k % 40 < 20) ? 3'b110 : 3'b000),
           3'($urandom_range(0, 7)) & ((k % 40 < 20) ? 3'b001 : 3'b111),
           ($urandom_range(0, 49) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
